fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces the single PC register and IF/ID latch with a PC generator plus a DEPTH-entry fetch queue. The queue decouples instruction-memory accesses from decode stalls and is flushed on branch/jump redirect. It sits between the instruction memory and the decode stage, driving {pc, instruction} pairs into decode with a valid/ready handshake.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry {pc, instr} queue toward decode.
// Define FETCH_BYPASS_EN to let an acked word reach decode in the same cycle when the queue is empty.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_o,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic [31:0]                imem_rdata_i,
  input  logic                       imem_ack_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q;
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic full, empty, ack_fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign imem_req_o  = !full && !redirect_i;
  assign imem_addr_o = pc_q;
  assign ack_fire    = imem_req_o && imem_ack_i;
  assign level_o     = count_q;

`ifdef FETCH_BYPASS_EN
  logic byp_valid;
  // ack_fire already excludes redirect, so the bypassed word is never stale
  assign byp_valid = empty && ack_fire;
  assign valid_o   = (!empty || byp_valid) && !redirect_i;
  assign instr_o   = byp_valid ? imem_rdata_i : ins_mem[rd_q];
  assign pc_o      = byp_valid ? pc_q : pc_mem[rd_q];
  assign pop       = valid_o && ready_i && !empty;
  assign push      = ack_fire && !(byp_valid && ready_i);
`else
  assign valid_o   = !empty && !redirect_i;
  assign instr_o   = ins_mem[rd_q];
  assign pc_o      = pc_mem[rd_q];
  assign pop       = valid_o && ready_i;
  assign push      = ack_fire;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (redirect_i) begin
      // target is forced word-aligned; any ack this cycle is dropped
      pc_q    <= redirect_pc_i & ~XLEN'(3);
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (ack_fire) pc_q <= pc_q + XLEN'(4);
      if (push) begin
        pc_mem[wr_q]  <= pc_q;
        ins_mem[wr_q] <= imem_rdata_i;
        wr_q          <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand sequences for latency, FIFO order and reset.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ack_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  level_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // instruction memory returns a word derived from its address
  assign imem_rdata_i = imem_addr_o ^ KEY;

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_ack_i(imem_ack_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .level_o(level_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic        ack, rdy, redir;
    logic [31:0] rpc;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc;
    logic [2:0]  e_lvl;
  } vec_t;

  vec_t        tv [22];
  logic [31:0] exp_q [$];
  logic [31:0] mpc;
  logic        mreq;

  initial begin
    //       ack  rdy  redir rpc            req  valid addr           pc             lvl
    tv[0]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h100,       32'h0,         3'd0};
    tv[1]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h104,       32'h100,       3'd1};
    tv[2]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h108,       32'h104,       3'd1};
    tv[3]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h10C,       32'h108,       3'd1};
    tv[4]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h110,       32'h10C,       3'd1};
    tv[5]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h114,       32'h10C,       3'd2};
    tv[6]  = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h118,       32'h10C,       3'd3};
    tv[7]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h11C,       32'h10C,       3'd4};
    tv[8]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b1,32'h11C,       32'h10C,       3'd4};
    tv[9]  = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h11C,       32'h110,       3'd3};
    tv[10] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h120,       32'h114,       3'd3};
    tv[11] = '{1'b1,1'b1,1'b1,32'h203,      1'b0,1'b0,32'h124,       32'h0,         3'd3};
    tv[12] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h200,       32'h0,         3'd0};
    tv[13] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h200,       32'h0,         3'd0};
    tv[14] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h204,       32'h200,       3'd1};
    tv[15] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,32'h204,       32'h0,         3'd0};
    tv[16] = '{1'b0,1'b0,1'b1,32'hFFFFFFF8, 1'b0,1'b0,32'h204,       32'h0,         3'd0};
    tv[17] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b0,32'hFFFFFFF8,  32'h0,         3'd0};
    tv[18] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'hFFFFFFFC,  32'hFFFFFFF8,  3'd1};
    tv[19] = '{1'b1,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h0,         32'hFFFFFFFC,  3'd1};
    tv[20] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b1,32'h4,         32'h0,         3'd1};
    tv[21] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h4,         32'h0,         3'd0};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.level", 32'(level_o), 32'd0);
    chk("rst.addr",  imem_addr_o, 32'h100);
    chk("rst.pc",    pc_o, 32'h0);
    chk("rst.instr", instr_o, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      imem_ack_i    = tv[i].ack;
      ready_i       = tv[i].rdy;
      redirect_i    = tv[i].redir;
      redirect_pc_i = tv[i].rpc;
      #1;
      chk($sformatf("v%0d.req", i),   32'(imem_req_o), 32'(tv[i].e_req));
      chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(tv[i].e_valid));
      chk($sformatf("v%0d.addr", i),  imem_addr_o, tv[i].e_addr);
      chk($sformatf("v%0d.level", i), 32'(level_o), 32'(tv[i].e_lvl));
      if (tv[i].e_valid) begin
        chk($sformatf("v%0d.pc", i),    pc_o, tv[i].e_pc);
        chk($sformatf("v%0d.instr", i), instr_o, tv[i].e_pc ^ KEY);
      end
    end

    // latency from an ack on an empty queue (pc_q is 0x4 here)
    @(negedge clk);
    imem_ack_i = 1'b1; ready_i = 1'b1; redirect_i = 1'b0;
    #1;
`ifdef FETCH_BYPASS_EN
    chk("byp.valid", 32'(valid_o), 32'd1);
    chk("byp.pc",    pc_o, 32'h4);
    chk("byp.instr", instr_o, 32'h4 ^ KEY);
`else
    chk("lat.valid0", 32'(valid_o), 32'd0);
`endif
    @(negedge clk);
    imem_ack_i = 1'b0;
    #1;
`ifdef FETCH_BYPASS_EN
    chk("byp.valid1", 32'(valid_o), 32'd0);
    chk("byp.level",  32'(level_o), 32'd0);
`else
    chk("lat.valid1", 32'(valid_o), 32'd1);
    chk("lat.pc",     pc_o, 32'h4);
    chk("lat.instr",  instr_o, 32'h4 ^ KEY);
`endif

    // redirect with unaligned target, then FIFO order with intermittent ack/ready
    @(negedge clk);
    imem_ack_i = 1'b1; ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h1002;
    #1;
    chk("rd2.req",   32'(imem_req_o), 32'd0);
    chk("rd2.valid", 32'(valid_o), 32'd0);
    mpc = 32'h1000;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      redirect_i = 1'b0;
      imem_ack_i = (i % 3 != 2);
      ready_i    = (i % 4 < 2);
      #1;
      mreq = (exp_q.size() < 4);
      chk($sformatf("sb%0d.req", i),   32'(imem_req_o), 32'(mreq));
      chk($sformatf("sb%0d.level", i), 32'(level_o), 32'(exp_q.size()));
      chk($sformatf("sb%0d.addr", i),  imem_addr_o, mpc);
      chk($sformatf("sb%0d.valid", i), 32'(valid_o), 32'(exp_q.size() > 0));
      if (ready_i && exp_q.size() > 0) begin
        chk($sformatf("sb%0d.pc", i),    pc_o, exp_q[0]);
        chk($sformatf("sb%0d.instr", i), instr_o, exp_q[0] ^ KEY);
        void'(exp_q.pop_front());
      end
      if (mreq && imem_ack_i) begin
        exp_q.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end

    // asynchronous reset mid-operation with an ack outstanding
    @(negedge clk);
    imem_ack_i = 1'b1; ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst.level", 32'(level_o), 32'd0);
    chk("arst.valid", 32'(valid_o), 32'd0);
    chk("arst.addr",  imem_addr_o, 32'h100);
    chk("arst.pc",    pc_o, 32'h0);
    chk("arst.instr", instr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    imem_ack_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
